lambda_dot_call: RTL and testbench

LAMBDA_DOT_CALL -- requirements
Module: lambda_dot_call

---
 rtl/lambda_pkg.sv | 25 ++
 rtl/lambda_mul.sv | 106 ++++++++++
 rtl/lambda_dot_call.sv | 172 +++++++++++++++++
 tb/tb_lambda_dot_call.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lambda_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lambda_pkg
// Brief    : Shared state encodings for the lambda call-block family.
// Revision : 1.0
// ============================================================================
package lambda_pkg;

    // Call-sequencer states; encodings are shared by every lambda call block.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALL = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } call_state_t;

    // Iterative multiplier states.
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/lambda_mul.sv
`default_nettype none
// ============================================================================
// Module   : lambda_mul
// Brief    : Shift-add multiplier, WIDTH iterations, request/out handshake.
// Revision : 1.0
// ============================================================================
module lambda_mul
    import lambda_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             request,
    output logic             out,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] result
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    mul_state_t       r_state;
    mul_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] w_mcand_nxt;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] w_mplier_nxt;
    logic [WIDTH-1:0] r_prod;
    logic [WIDTH-1:0] w_prod_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic [c_CW-1:0]  w_cnt_nxt;
    logic             r_out;
    logic             w_out_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= MUL_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_out    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_prod   <= w_prod_nxt;
            r_cnt    <= w_cnt_nxt;
            r_out    <= w_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_prod_nxt   = r_prod;
        w_cnt_nxt    = r_cnt;
        w_out_nxt    = r_out;
        case (r_state)
            MUL_IDLE: begin
                if (request) begin
                    w_mcand_nxt  = in1;
                    w_mplier_nxt = in2;
                    w_prod_nxt   = '0;
                    w_cnt_nxt    = '0;
                    w_state_nxt  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                // A dropped request abandons the product so a restart never sees stale data.
                if (!request) begin
                    w_state_nxt = MUL_IDLE;
                end else begin
                    if (r_mplier[0]) begin
                        w_prod_nxt = r_prod + r_mcand;
                    end
                    w_mcand_nxt  = r_mcand << 1;
                    w_mplier_nxt = r_mplier >> 1;
                    w_cnt_nxt    = r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        w_out_nxt   = 1'b1;
                        w_state_nxt = MUL_DONE;
                    end
                end
            end
            MUL_DONE: begin
                if (!request) begin
                    w_out_nxt   = 1'b0;
                    w_state_nxt = MUL_IDLE;
                end
            end
            default: begin
                w_out_nxt   = 1'b0;
                w_state_nxt = MUL_IDLE;
            end
        endcase
    end

    assign out    = r_out;
    assign result = r_prod;

endmodule
`default_nettype wire

// File: rtl/lambda_dot_call.sv
`default_nettype none
// ============================================================================
// Module   : lambda_dot_call
// Brief    : Dot product of TERMS lanes via one shared iterative multiplier.
//            LAMBDA_DOT_SATURATE_EN: clamp accumulation instead of wrapping.
// Revision : 1.0
// ============================================================================
module lambda_dot_call
    import lambda_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TERMS = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   request,
    output logic                   out,
    input  logic [TERMS*WIDTH-1:0] in1,
    input  logic [TERMS*WIDTH-1:0] in2,
    output logic [WIDTH-1:0]       result
);

    localparam int              c_KW     = (TERMS > 1) ? $clog2(TERMS) : 1;
    localparam int              c_LANES  = 1 << c_KW;
    localparam logic [c_KW-1:0] c_LAST_K = c_KW'(TERMS - 1);

    call_state_t        r_state;
    call_state_t        w_state_nxt;
    logic [TERMS*WIDTH-1:0] r_op1;
    logic [TERMS*WIDTH-1:0] r_op2;
    logic               w_capture;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_acc_add;
    logic [c_KW-1:0]    r_k;
    logic [c_KW-1:0]    w_k_nxt;
    logic               r_mul_req;
    logic               w_mul_req_nxt;
    logic               r_out;
    logic               w_out_nxt;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   w_result_nxt;

    logic [WIDTH-1:0]   w_lane1 [c_LANES];
    logic [WIDTH-1:0]   w_lane2 [c_LANES];
    logic [WIDTH-1:0]   w_mul_in1;
    logic [WIDTH-1:0]   w_mul_in2;
    logic               w_mul_out;
    logic [WIDTH-1:0]   w_product;

    // Lane table padded to a power of two so any r_k value selects a defined lane.
    for (genvar g = 0; g < c_LANES; g++) begin : g_lane
        if (g < TERMS) begin : g_used
            assign w_lane1[g] = r_op1[g*WIDTH +: WIDTH];
            assign w_lane2[g] = r_op2[g*WIDTH +: WIDTH];
        end else begin : g_pad
            assign w_lane1[g] = '0;
            assign w_lane2[g] = '0;
        end
    end

    assign w_mul_in1 = w_lane1[r_k];
    assign w_mul_in2 = w_lane2[r_k];

    lambda_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clock   (clock),
        .reset   (reset),
        .request (r_mul_req),
        .out     (w_mul_out),
        .in1     (w_mul_in1),
        .in2     (w_mul_in2),
        .result  (w_product)
    );

`ifdef LAMBDA_DOT_SATURATE_EN
    logic [WIDTH:0] w_sum;
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_product};
    assign w_acc_add = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
    assign w_acc_add = r_acc + w_product;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_op1     <= '0;
            r_op2     <= '0;
            r_acc     <= '0;
            r_k       <= '0;
            r_mul_req <= 1'b0;
            r_out     <= 1'b0;
            r_result  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_k       <= w_k_nxt;
            r_mul_req <= w_mul_req_nxt;
            r_out     <= w_out_nxt;
            r_result  <= w_result_nxt;
            if (w_capture) begin
                r_op1 <= in1;
                r_op2 <= in2;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_acc_nxt     = r_acc;
        w_k_nxt       = r_k;
        w_mul_req_nxt = r_mul_req;
        w_out_nxt     = r_out;
        w_result_nxt  = r_result;
        case (r_state)
            IDLE: begin
                if (request) begin
                    w_capture     = 1'b1;
                    w_acc_nxt     = '0;
                    w_k_nxt       = '0;
                    w_mul_req_nxt = 1'b1;
                    w_state_nxt   = CALL;
                end
            end
            CALL: begin
                if (!request) begin
                    w_mul_req_nxt = 1'b0;
                    w_state_nxt   = IDLE;
                end else if (w_mul_out) begin
                    w_acc_nxt     = w_acc_add;
                    w_mul_req_nxt = 1'b0;
                    w_state_nxt   = WAIT;
                end
            end
            WAIT: begin
                // Hold until the multiplier has dropped out, so its old product is never reused.
                if (!request) begin
                    w_mul_req_nxt = 1'b0;
                    w_state_nxt   = IDLE;
                end else if (!w_mul_out) begin
                    if (r_k < c_LAST_K) begin
                        w_k_nxt       = r_k + 1'b1;
                        w_mul_req_nxt = 1'b1;
                        w_state_nxt   = CALL;
                    end else begin
                        w_result_nxt  = r_acc;
                        w_out_nxt     = 1'b1;
                        w_state_nxt   = DONE;
                    end
                end
            end
            DONE: begin
                if (!request) begin
                    w_out_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_mul_req_nxt = 1'b0;
                w_out_nxt     = 1'b0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    assign out    = r_out;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_lambda_dot_call.sv
`default_nettype none
// ============================================================================
// Module   : tb_lambda_dot_call
// Brief    : Directed bench for lambda_dot_call with a dot-product latency model.
// Revision : 1.0
// ============================================================================
module tb_lambda_dot_call;

    localparam int W = 8;
`ifdef LAMBDA_DOT_SATURATE_EN
    localparam int WRAP_EXP = 255;
`else
    localparam int WRAP_EXP = 69;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_a = 1'b0;
    logic        req_b = 1'b0;
    logic [15:0] in1_a = '0;
    logic [15:0] in2_a = '0;
    logic [7:0]  in1_b = '0;
    logic [7:0]  in2_b = '0;
    logic        out_a;
    logic        out_b;
    logic [7:0]  res_a;
    logic [7:0]  res_b;

    int n_checks = 0;
    int n_errors = 0;

    // Model: per instance 0=idle, 1=computing, 2=done; edges counted from acceptance.
    int          m_state [2];
    int          m_cnt   [2];
    logic [15:0] m_a     [2];
    logic [15:0] m_b     [2];
    int          m_out   [2];
    int          m_res   [2];

    always #5 clock = ~clock;

    lambda_dot_call #(.WIDTH(W), .TERMS(2)) dut_a (
        .clock   (clock),
        .reset   (reset),
        .request (req_a),
        .out     (out_a),
        .in1     (in1_a),
        .in2     (in2_a),
        .result  (res_a)
    );

    lambda_dot_call #(.WIDTH(W), .TERMS(1)) dut_b (
        .clock   (clock),
        .reset   (reset),
        .request (req_b),
        .out     (out_b),
        .in1     (in1_b),
        .in2     (in2_b),
        .result  (res_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dot(input int terms, input logic [15:0] a, input logic [15:0] b);
        int acc = 0;
        int p;
        for (int k = 0; k < terms; k++) begin
            p = (int'(a[k*8 +: 8]) * int'(b[k*8 +: 8])) % 256;
            acc = acc + p;
`ifdef LAMBDA_DOT_SATURATE_EN
            if (acc > 255) acc = 255;
`else
            acc = acc % 256;
`endif
        end
        return acc;
    endfunction

    task automatic model_step(input int i, input logic req, input logic [15:0] a,
                              input logic [15:0] b, input int terms);
        case (m_state[i])
            0: if (req) begin
                m_state[i] = 1; m_cnt[i] = 0; m_a[i] = a; m_b[i] = b;
            end
            1: if (!req) begin
                m_state[i] = 0;
            end else begin
                m_cnt[i]++;
                if (m_cnt[i] == terms * (W + 4)) begin
                    m_state[i] = 2;
                    m_out[i]   = 1;
                    m_res[i]   = dot(terms, m_a[i], m_b[i]);
                end
            end
            default: if (!req) begin
                m_state[i] = 0; m_out[i] = 0;
            end
        endcase
    endtask

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_state[i] = 0; m_cnt[i] = 0; m_out[i] = 0; m_res[i] = 0;
            end
        end else begin
            model_step(0, req_a, in1_a, in2_a, 2);
            model_step(1, req_b, {8'h00, in1_b}, {8'h00, in2_b}, 1);
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("model.a.out",    int'(out_a), m_out[0]);
            check("model.a.result", int'(res_a), m_res[0]);
            check("model.b.out",    int'(out_b), m_out[1]);
            check("model.b.result", int'(res_b), m_res[1]);
        end
    end

    // Returns right after the accepting edge E0.
    task automatic start(input int sel, input logic [15:0] a, input logic [15:0] b);
        @(negedge clock);
        if (sel == 0) begin
            req_a = 1'b1; in1_a = a; in2_a = b;
        end else begin
            req_b = 1'b1; in1_b = a[7:0]; in2_b = b[7:0];
        end
        @(posedge clock);
    endtask

    task automatic wait_out(input int sel, input int j0, input int exp_lat,
                            input int exp_res, input string name);
        int   j = j0;
        logic o;
        do begin
            @(posedge clock);
            j++;
            #1;
            o = (sel == 0) ? out_a : out_b;
        end while (!o && j < 200);
        check({name, ".latency"}, j, exp_lat);
        check({name, ".result"}, (sel == 0) ? int'(res_a) : int'(res_b), exp_res);
    endtask

    task automatic drop(input int sel, input string name);
        @(negedge clock);
        if (sel == 0) req_a = 1'b0;
        else          req_b = 1'b0;
        @(posedge clock);
        #1;
        check({name, ".out"}, (sel == 0) ? int'(out_a) : int'(out_b), 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        check("reset.a.out",    int'(out_a), 0);
        check("reset.a.result", int'(res_a), 0);
        check("reset.b.out",    int'(out_b), 0);
        check("reset.b.result", int'(res_b), 0);
        reset = 1'b0;

        // 3*7 + 7*10 = 91
        start(0, 16'h0703, 16'h0A07);
        wait_out(0, 0, 24, 91, "basic");
        drop(0, "basic.drop");
        check("basic.result_kept", int'(res_a), 91);

        // 15*15 + 10*10 = 325
        start(0, 16'h0A0F, 16'h0A0F);
        wait_out(0, 0, 24, WRAP_EXP, "wrap");
        drop(0, "wrap.drop");

        start(0, 16'h0703, 16'h0A07);
        repeat (9) @(posedge clock);
        @(negedge clock) req_a = 1'b0;
        @(posedge clock);
        #1;
        check("abort.out",    int'(out_a), 0);
        check("abort.result", int'(res_a), WRAP_EXP);
        start(0, 16'h0703, 16'h0A07);
        wait_out(0, 0, 24, 91, "restart");
        drop(0, "restart.drop");

        start(0, 16'h0703, 16'h0A07);
        repeat (2) @(posedge clock);
        @(negedge clock);
        in1_a = 16'hFFFF;
        in2_a = 16'hFFFF;
        wait_out(0, 2, 24, 91, "hold");
        drop(0, "hold.drop");

        start(0, 16'h0A0F, 16'h0A0F);
        repeat (5) @(posedge clock);
        #2;
        check("areset.pre_result", int'(res_a), 91);
        reset = 1'b1;
        #1;
        check("areset.out",    int'(out_a), 0);
        check("areset.result", int'(res_a), 0);
        @(negedge clock);
        req_a = 1'b0;
        reset = 1'b0;

        start(1, 16'h0005, 16'h0006);
        wait_out(1, 0, 12, 30, "t1.first");
        drop(1, "t1.first.drop");
        start(1, 16'h0000, 16'h00C8);
        wait_out(1, 0, 12, 0, "t1.zero");
        drop(1, "t1.zero.drop");

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
